adc0809_emu: RTL

//  Synthesizable responder for the ADC0809 handshake: the chip side of our
//  ADC0809 controller. Takes START/ALE/OE/ad_clk from the controller and answers

---
 rtl/adc0809_emu_if.sv | 27 ++
 rtl/adc0809_emu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/adc0809_emu_if.sv
// ADC0809 pin bundle shared by the controller (master) and the emulated chip (slave).
// Latency: none, wires only.
// Backpressure: none; the ADC0809 handshake is start/eoc level signalling.
interface adc0809_if;
    logic        ad_clk;
    logic        start;
    logic        ale;
    logic [2:0]  addr;
    logic        oe;
    logic [63:0] ain;
    logic        eoc;
    logic [7:0]  d;
    logic        d_oe;
    logic        busy;

    // Controller side drives the strobes and the analog channels.
    modport master (
        output ad_clk, start, ale, addr, oe, ain,
        input  eoc, d, d_oe, busy
    );

    // Emulated chip side answers with eoc and data.
    modport slave (
        input  ad_clk, start, ale, addr, oe, ain,
        output eoc, d, d_oe, busy
    );
endinterface

// File: rtl/adc0809_emu.sv
// ADC0809 chip-side responder: syncs controller strobes and converts one of 8 digital channels.
// Latency: CONV_CYCLES ad_clk rises from synced start fall to eoc; oe pin to d is SYNC_STAGES+1.
// Backpressure: none; a start rise during conversion aborts and re-arms. Optional ADC_DITHER_EN.
module adc0809_emu #(
    parameter int CONV_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input logic       sys_clk,
    input logic       rst,
    adc0809_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARMED, CONVERT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(CONV_CYCLES - 1);

    // Pin order inside each synchronizer stage: {ad_clk, oe, ale, start}.
    logic [SYNC_STAGES*4-1:0] sync_q;
    logic [3:0]               sync_s;
    logic [3:0]               prev_q;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] sample_q, sample_d;
    logic [7:0] result_q, result_d;
    logic [2:0] ch_addr_q;
    logic       eoc_q, eoc_d;
    logic [7:0] d_q;
    logic       d_oe_q;

    logic start_rise, start_fall, ale_rise, adclk_rise, oe_s;

`ifdef ADC_DITHER_EN
    logic [7:0] lfsr_q, lfsr_d;
`endif

    assign sync_s     = sync_q[SYNC_STAGES*4-1 -: 4];
    assign start_rise =  sync_s[0] & ~prev_q[0];
    assign start_fall = ~sync_s[0] &  prev_q[0];
    assign ale_rise   =  sync_s[1] & ~prev_q[1];
    assign oe_s       =  sync_s[2];
    assign adclk_rise =  sync_s[3] & ~prev_q[3];

    // Synchronizer chain plus one stage of history for edge detection.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[(SYNC_STAGES-1)*4-1:0], bus.ad_clk, bus.oe, bus.ale, bus.start};
            prev_q <= sync_s;
        end
    end

    // Channel latch; a running conversion already holds its own sample.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) ch_addr_q <= 3'd0;
        else if (ale_rise) ch_addr_q <= bus.addr;
    end

    // Conversion state and datapath registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            sample_q <= 8'd0;
            result_q <= 8'd0;
            eoc_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            result_q <= result_d;
            eoc_q    <= eoc_d;
        end
    end

`ifdef ADC_DITHER_EN
    // Dither LFSR, stepped once per completed conversion.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) lfsr_q <= 8'h01;
        else     lfsr_q <= lfsr_d;
    end
`endif

    // Next-state logic; a start rise in CONVERT beats a simultaneous count completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        result_d = result_q;
`ifdef ADC_DITHER_EN
        lfsr_d   = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_rise) state_d = ARMED;
            end
            ARMED: begin
                cnt_d = 8'd0;
                if (start_fall) begin
                    state_d  = CONVERT;
                    sample_d = bus.ain[{ch_addr_q, 3'b000} +: 8];
                end
            end
            CONVERT: begin
                if (start_rise) begin
                    state_d = ARMED;
                    cnt_d   = 8'd0;
                end else if (adclk_rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef ADC_DITHER_EN
                case (lfsr_q[1:0])
                    2'b01:   result_d = (sample_q == 8'hFF) ? 8'hFF : sample_q + 8'd1;
                    2'b10:   result_d = (sample_q == 8'h00) ? 8'h00 : sample_q - 8'd1;
                    default: result_d = sample_q;
                endcase
                lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
                result_d = sample_q;
`endif
            end
            default: state_d = IDLE;
        endcase
        // eoc tracks "heading to IDLE": low the cycle after arming, high the cycle after DONE.
        eoc_d = (state_d == IDLE);
    end

    // Registered output path so d and d_oe change together.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            d_q    <= 8'd0;
            d_oe_q <= 1'b0;
        end else begin
            d_q    <= oe_s ? result_q : 8'h00;
            d_oe_q <= oe_s;
        end
    end

    assign bus.eoc  = eoc_q;
    assign bus.d    = d_q;
    assign bus.d_oe = d_oe_q;
    assign bus.busy = (state_q == ARMED) || (state_q == CONVERT);
endmodule
